int_alu_pipe: RTL and testbench
===============================

INT_ALU_PIPE -- requirements
Module: int_alu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter LATENCY, default 2, pipeline stages from issue to CDB request; legal range 1..4.
REQ-003 SHALL have parameter TAG_W, default 6, ROB tag width.
REQ-004 SHALL have port clk  input  1  single clock, rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port flush  input  1  discard all in-flight ops.
REQ-007 SHALL have port issue_valid  input  1  issue queue presents an op.
REQ-008 SHALL have port issue_ready  output  1  unit accepts the op this cycle.
REQ-009 SHALL have port issue_op  input  int_op_t  opcode[6:0], func3[2:0], func7[6:0], rs1_data, rs2_data (XLEN each), rd_tag (TAG_W), wb_valid.
REQ-010 SHALL have port cdb_req  output  1  result at output stage awaiting CDB.
REQ-011 SHALL have port cdb_grant  input  1  CDB arbiter takes the result this cycle.
REQ-012 SHALL have port cdb_out  output  int_cdb_t  valid, tag, result (XLEN), branch, branch_taken.
REQ-013 SHALL have port occupancy  output  $clog2(LATENCY+1)  count of valid stages.

Function
REQ-014 SHALL hold LATENCY stages, each with a valid bit; op captured into stage 0 when issue_valid && issue_ready.
REQ-015 SHALL compute the result combinationally at stage 0 input; later stages only carry it.
REQ-016 SHALL advance stage k into k+1 when k+1 is empty or k+1 advances in the same cycle (elastic, no bubbles required).
REQ-017 SHALL advance the output stage only on cdb_grant; cdb_req equals output-stage valid; grant without req is ignored.
REQ-018 SHALL drive issue_ready = !flush && (stage 0 empty || stage 0 advances this cycle).
REQ-019 SHALL give minimum latency LATENCY cycles from accept to cdb_req with continuous grant; sustained throughput one op/cycle.
REQ-020 SHALL hold cdb_out stable while cdb_req=1 and cdb_grant=0.
REQ-021 R-type (0110011): func3 0 add (func7 00) / sub (func7 20); 2 slt signed; 3 sltu; 4 xor; 6 or; 7 and; other func3/func7 result 0.
REQ-022 I-type (0010011): func3 0 addi, 2 slti, 3 sltiu, 4 xori, 6 ori, 7 andi, rs2_data carrying sign-extended imm.
REQ-023 LUI (0110111): result = rs2_data.
REQ-024 BRANCH (1100011): func3 0 eq, 1 ne, 4 lt signed, 5 ge signed, 6 ltu, 7 geu into branch_taken; branch=1, valid=1, result=0; other func3 taken=0.
REQ-025 Non-branch: valid = wb_valid, branch=0, branch_taken=0; unknown opcode result 0, valid = wb_valid.
REQ-026 All arithmetic modulo 2^XLEN; carries discarded.
REQ-027 cdb_out SHALL be all-zero when cdb_req=0.
REQ-028 flush SHALL clear every stage valid at the next edge, override same-cycle accept and grant, and set occupancy 0.
REQ-029 occupancy SHALL be the population count of stage valids, updated each edge; simultaneous accept and grant leave it unchanged when full.

Reset
REQ-030 rst_n low SHALL asynchronously clear all stage valids and payloads; cdb_req=0, cdb_out=0, occupancy=0, issue_ready=1 once flush=0.
REQ-031 Reset mid-operation SHALL discard all in-flight ops with no CDB emission.

Configuration
REQ-032 Macro INT_ALU_SHIFT_EN defined: R-type func3 1 sll, 5 srl (func7 00) / sra (func7 20); I-type slli/srli/srai identically, shift amount rs2_data[$clog2(XLEN)-1:0].
REQ-033 Macro undefined: those encodings yield result 0 with valid = wb_valid; no shifter logic.

Structure
REQ-034 int_op_t, int_cdb_t and opcode constants (R_TYPE, I_TYPE, LUI_TYPE, BRANCH_TYPE) SHALL reside in the shared utils package.
REQ-035 Compute logic SHALL be sub-module int_alu_core (combinational); the pipeline uses the existing parameterised flop with enable and flush.

Verification
REQ-036 add rs1=5 rs2=7 tag=3, LATENCY=2, grant held 1 -> cdb_req at cycle 2, result 12, tag 3, valid 1.
REQ-037 slt rs1=FFFFFFFF rs2=1 -> result 1; sltu same operands -> result 0.
REQ-038 blt rs1=-3 rs2=2 -> branch=1, branch_taken=1, result 0; bgeu same operands -> taken=1.
REQ-039 4 back-to-back ops, grant low -> issue_ready drops after LATENCY accepts, occupancy=LATENCY, cdb_out stable; grant high -> results in issue order, one per cycle.
REQ-040 flush with occupancy 2 and same-cycle issue_valid -> next cycle occupancy 0, cdb_req 0, op dropped.
REQ-041 sra rs1=80000000 rs2=4 with INT_ALU_SHIFT_EN -> F8000000; without macro -> 0.

Source files
------------

// File: rtl/int_alu_pipe_pkg.sv
// Shared types and opcode constants for the integer ALU pipe.
// Bus widths follow XLEN_DEF/TAG_W_DEF; module parameters must match them.
package int_alu_pipe_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 6;

  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE      = 7'b0010011;
  localparam logic [6:0] LUI_TYPE    = 7'b0110111;
  localparam logic [6:0] BRANCH_TYPE = 7'b1100011;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic [XLEN_DEF-1:0]  rs1_data;
    logic [XLEN_DEF-1:0]  rs2_data;
    logic [TAG_W_DEF-1:0] rd_tag;
    logic                 wb_valid;
  } int_op_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]  result;
    logic                 branch;
    logic                 branch_taken;
  } int_cdb_t;

endpackage

// File: rtl/int_alu_core.sv
// Combinational integer ALU / branch resolver; shifts only with INT_ALU_SHIFT_EN.
// Latency: 0 cycles. Backpressure: none (pure function of op).
module int_alu_core
  import int_alu_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  int_op_t  op,
  output int_cdb_t res
);

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] alu;
  logic            lt_s;
  logic            lt_u;
  logic            is_r;
  logic            f7_plain;
  logic            f7_alt;
  logic            taken;

  assign a        = op.rs1_data;
  assign b        = op.rs2_data;
  assign lt_s     = $signed(a) < $signed(b);
  assign lt_u     = a < b;
  assign is_r     = (op.opcode == R_TYPE);
  assign f7_plain = (op.func7 == 7'h00);
  assign f7_alt   = (op.func7 == 7'h20);

`ifdef INT_ALU_SHIFT_EN
  localparam int SHW = $clog2(XLEN);
  logic [SHW-1:0] sh;
  assign sh = b[SHW-1:0];
`endif

  // I-type reuses func7 bits as immediate, so only R-type qualifies on func7
  // outside the shift encodings.
  always_comb begin
    alu = '0;
    case (op.func3)
      3'd0: begin
        if (!is_r || f7_plain) alu = a + b;
        else if (f7_alt)       alu = a - b;
      end
      3'd2: if (!is_r || f7_plain) alu = {{(XLEN-1){1'b0}}, lt_s};
      3'd3: if (!is_r || f7_plain) alu = {{(XLEN-1){1'b0}}, lt_u};
      3'd4: if (!is_r || f7_plain) alu = a ^ b;
      3'd6: if (!is_r || f7_plain) alu = a | b;
      3'd7: if (!is_r || f7_plain) alu = a & b;
`ifdef INT_ALU_SHIFT_EN
      3'd1: if (f7_plain) alu = a << sh;
      3'd5: begin
        if (f7_plain)    alu = a >> sh;
        else if (f7_alt) alu = $signed(a) >>> sh;
      end
`endif
      default: alu = '0;
    endcase
  end

  always_comb begin
    case (op.func3)
      3'd0:    taken = (a == b);
      3'd1:    taken = (a != b);
      3'd4:    taken = lt_s;
      3'd5:    taken = !lt_s;
      3'd6:    taken = lt_u;
      3'd7:    taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    res     = '0;
    res.tag = op.rd_tag;
    case (op.opcode)
      R_TYPE, I_TYPE: begin
        res.valid  = op.wb_valid;
        res.result = alu;
      end
      LUI_TYPE: begin
        res.valid  = op.wb_valid;
        res.result = b;
      end
      BRANCH_TYPE: begin
        res.valid        = 1'b1;
        res.branch       = 1'b1;
        res.branch_taken = taken;
      end
      default: res.valid = op.wb_valid;
    endcase
  end

endmodule

// File: rtl/int_alu_pipe_flop.sv
// Parameterised register with load enable and synchronous clear.
// Latency: 1 cycle. Backpressure: none; clr takes priority over en.
module int_alu_pipe_flop #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      data_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/int_alu_pipe.sv
// Elastic LATENCY-stage integer ALU pipe feeding the CDB; INT_ALU_SHIFT_EN adds shifts.
// Latency: LATENCY cycles accept-to-cdb_req. Backpressure: output stage holds until cdb_grant.
module int_alu_pipe
  import int_alu_pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int LATENCY = 2,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  int_op_t                    issue_op,
  output logic                       cdb_req,
  input  logic                       cdb_grant,
  output int_cdb_t                   cdb_out,
  output logic [$clog2(LATENCY+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(LATENCY + 1);
  localparam int PAY_W = XLEN + TAG_W + 3;

  int_cdb_t           core_res;
  logic [PAY_W-1:0]   core_pay;
  logic [PAY_W-1:0]   pay_q [LATENCY];
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] adv;
  logic [LATENCY-1:0] load;
  logic               accept;
  logic [OCC_W-1:0]   occ;
  int_cdb_t           out_pay;

  int_alu_core #(.XLEN(XLEN)) u_core (
    .op  (issue_op),
    .res (core_res)
  );

  assign core_pay = core_res;

  // A stage moves on if any later stage has a hole, or everything ahead is
  // full and the CDB takes the head this cycle.
  always_comb begin
    logic hole;
    adv  = '0;
    load = '0;
    for (int k = 0; k < LATENCY; k++) begin
      hole = cdb_grant;
      for (int j = k + 1; j < LATENCY; j++) begin
        hole = hole | !vld_q[j];
      end
      adv[k] = vld_q[k] && hole;
    end
    load[0] = accept;
    for (int k = 1; k < LATENCY; k++) begin
      load[k] = adv[k-1];
    end
  end

  assign issue_ready = !flush && (!vld_q[0] || adv[0]);
  assign accept      = issue_valid && issue_ready;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic [PAY_W-1:0] pay_in;
    if (k == 0) begin : g_first
      assign pay_in = core_pay;
    end else begin : g_rest
      assign pay_in = pay_q[k-1];
    end

    int_alu_pipe_flop #(.W(1)) u_vld (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (load[k] || adv[k]),
      .clr   (flush),
      .din   (load[k]),
      .q     (vld_q[k])
    );

    int_alu_pipe_flop #(.W(PAY_W)) u_pay (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (load[k]),
      .clr   (flush),
      .din   (pay_in),
      .q     (pay_q[k])
    );
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < LATENCY; k++) begin
      occ = occ + OCC_W'(vld_q[k]);
    end
  end

  assign occupancy = occ;
  assign cdb_req   = vld_q[LATENCY-1];
  assign out_pay   = pay_q[LATENCY-1];
  assign cdb_out   = cdb_req ? out_pay : '0;

endmodule

// File: tb/tb_int_alu_pipe.sv
// Directed bench for int_alu_pipe: vector table for the ALU, hand sequences for
// backpressure, flush and mid-operation reset.
module tb_int_alu_pipe;
  import int_alu_pipe_pkg::*;

  localparam int LAT = 2;
  localparam int NV  = 19;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     flush = 1'b0;
  logic     issue_valid = 1'b0;
  logic     cdb_grant = 1'b0;
  int_op_t  issue_op = '0;
  logic     issue_ready;
  logic     cdb_req;
  int_cdb_t cdb_out;
  logic [1:0] occupancy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int_op_t  op;
    int_cdb_t exp;
  } vec_t;

  vec_t     vecs [NV];
  int_op_t  seq_op [4];
  int_cdb_t seq_exp [4];

  int_alu_pipe #(.XLEN(32), .LATENCY(LAT), .TAG_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .cdb_req     (cdb_req),
    .cdb_grant   (cdb_grant),
    .cdb_out     (cdb_out),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] cdb2v(input int_cdb_t c);
    return {23'b0, c};
  endfunction

  function automatic int_op_t mk_op(input logic [6:0] opc, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] a,
                                    input logic [31:0] b, input logic [5:0] tag,
                                    input logic wb);
    int_op_t o;
    o.opcode   = opc;
    o.func3    = f3;
    o.func7    = f7;
    o.rs1_data = a;
    o.rs2_data = b;
    o.rd_tag   = tag;
    o.wb_valid = wb;
    return o;
  endfunction

  function automatic int_cdb_t mk_cdb(input logic v, input logic [5:0] tag,
                                      input logic [31:0] r, input logic br,
                                      input logic tk);
    int_cdb_t c;
    c.valid        = v;
    c.tag          = tag;
    c.result       = r;
    c.branch       = br;
    c.branch_taken = tk;
    return c;
  endfunction

  initial begin
    int  lat;
    int  acc;
    logic seen;
    logic [31:0] sra_exp;
    logic [31:0] sll_exp;

`ifdef INT_ALU_SHIFT_EN
    sra_exp = 32'hF800_0000;
    sll_exp = 32'h8000_0000;
`else
    sra_exp = 32'h0;
    sll_exp = 32'h0;
`endif

    vecs[0]  = '{mk_op(R_TYPE, 3'd0, 7'h00, 32'd5, 32'd7, 6'd3, 1'b1), mk_cdb(1'b1, 6'd3, 32'd12, 1'b0, 1'b0)};
    vecs[1]  = '{mk_op(R_TYPE, 3'd0, 7'h20, 32'd5, 32'd7, 6'd4, 1'b1), mk_cdb(1'b1, 6'd4, 32'hFFFF_FFFE, 1'b0, 1'b0)};
    vecs[2]  = '{mk_op(R_TYPE, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 6'd5, 1'b1), mk_cdb(1'b1, 6'd5, 32'd1, 1'b0, 1'b0)};
    vecs[3]  = '{mk_op(R_TYPE, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 6'd6, 1'b1), mk_cdb(1'b1, 6'd6, 32'd0, 1'b0, 1'b0)};
    vecs[4]  = '{mk_op(R_TYPE, 3'd4, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 6'd7, 1'b1), mk_cdb(1'b1, 6'd7, 32'h0FF0_0FF0, 1'b0, 1'b0)};
    vecs[5]  = '{mk_op(R_TYPE, 3'd6, 7'h00, 32'hF0F0_F0F0, 32'h0000_FFFF, 6'd8, 1'b1), mk_cdb(1'b1, 6'd8, 32'hF0F0_FFFF, 1'b0, 1'b0)};
    vecs[6]  = '{mk_op(R_TYPE, 3'd7, 7'h00, 32'hF0F0_F0F0, 32'h0000_FFFF, 6'd9, 1'b1), mk_cdb(1'b1, 6'd9, 32'h0000_F0F0, 1'b0, 1'b0)};
    vecs[7]  = '{mk_op(I_TYPE, 3'd0, 7'h7F, 32'hFFFF_FFFF, 32'd1, 6'd10, 1'b1), mk_cdb(1'b1, 6'd10, 32'd0, 1'b0, 1'b0)};
    vecs[8]  = '{mk_op(I_TYPE, 3'd2, 7'h7F, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 6'd11, 1'b1), mk_cdb(1'b1, 6'd11, 32'd1, 1'b0, 1'b0)};
    vecs[9]  = '{mk_op(LUI_TYPE, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h1234_5000, 6'd12, 1'b1), mk_cdb(1'b1, 6'd12, 32'h1234_5000, 1'b0, 1'b0)};
    vecs[10] = '{mk_op(BRANCH_TYPE, 3'd4, 7'h00, 32'hFFFF_FFFD, 32'd2, 6'd13, 1'b0), mk_cdb(1'b1, 6'd13, 32'd0, 1'b1, 1'b1)};
    vecs[11] = '{mk_op(BRANCH_TYPE, 3'd7, 7'h00, 32'hFFFF_FFFD, 32'd2, 6'd14, 1'b0), mk_cdb(1'b1, 6'd14, 32'd0, 1'b1, 1'b1)};
    vecs[12] = '{mk_op(BRANCH_TYPE, 3'd0, 7'h00, 32'd4, 32'd5, 6'd15, 1'b1), mk_cdb(1'b1, 6'd15, 32'd0, 1'b1, 1'b0)};
    vecs[13] = '{mk_op(BRANCH_TYPE, 3'd2, 7'h00, 32'd4, 32'd4, 6'd16, 1'b1), mk_cdb(1'b1, 6'd16, 32'd0, 1'b1, 1'b0)};
    vecs[14] = '{mk_op(7'h0B, 3'd0, 7'h00, 32'd5, 32'd7, 6'd17, 1'b1), mk_cdb(1'b1, 6'd17, 32'd0, 1'b0, 1'b0)};
    vecs[15] = '{mk_op(R_TYPE, 3'd0, 7'h01, 32'd5, 32'd7, 6'd18, 1'b1), mk_cdb(1'b1, 6'd18, 32'd0, 1'b0, 1'b0)};
    vecs[16] = '{mk_op(R_TYPE, 3'd0, 7'h00, 32'd1, 32'd2, 6'd19, 1'b0), mk_cdb(1'b0, 6'd19, 32'd3, 1'b0, 1'b0)};
    vecs[17] = '{mk_op(R_TYPE, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 6'd20, 1'b1), mk_cdb(1'b1, 6'd20, sra_exp, 1'b0, 1'b0)};
    vecs[18] = '{mk_op(I_TYPE, 3'd1, 7'h00, 32'd1, 32'd31, 6'd21, 1'b1), mk_cdb(1'b1, 6'd21, sll_exp, 1'b0, 1'b0)};

    for (int i = 0; i < 4; i++) begin
      seq_op[i]  = mk_op(R_TYPE, 3'd0, 7'h00, 32'(i), 32'd100, 6'(40 + i), 1'b1);
      seq_exp[i] = mk_cdb(1'b1, 6'(40 + i), 32'(100 + i), 1'b0, 1'b0);
    end

    // Reset state
    #12;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_req", 64'(cdb_req), 64'd0);
    chk("rst_cdb", cdb2v(cdb_out), 64'd0);
    chk("rst_ready", 64'(issue_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, grant held high
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      issue_op    = vecs[i].op;
      issue_valid = 1'b1;
      cdb_grant   = 1'b1;
      @(negedge clk);
      issue_valid = 1'b0;
      lat = 1;
      while (!cdb_req && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("lat[%0d]", i), 64'(lat), 64'(LAT));
      chk($sformatf("cdb[%0d]", i), cdb2v(cdb_out), cdb2v(vecs[i].exp));
      @(negedge clk);
      chk($sformatf("idle_cdb[%0d]", i), {63'b0, cdb_req}, 64'd0);
    end
    chk("idle_cdb_zero", cdb2v(cdb_out), 64'd0);

    // Backpressure: grant low, four ops offered back-to-back
    cdb_grant = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      issue_op    = seq_op[acc];
      issue_valid = 1'b1;
      #1;
      chk($sformatf("bp_ready[%0d]", c), 64'(issue_ready), 64'(c < LAT));
      if (c >= LAT) chk($sformatf("bp_hold[%0d]", c), cdb2v(cdb_out), cdb2v(seq_exp[0]));
      if (issue_ready) acc++;
    end
    @(negedge clk);
    chk("bp_accepts", 64'(acc), 64'(LAT));
    chk("bp_occ", 64'(occupancy), 64'(LAT));
    chk("bp_hold_final", cdb2v(cdb_out), cdb2v(seq_exp[0]));
    cdb_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_req[%0d]", k), 64'(cdb_req), 64'd1);
      chk($sformatf("drain_cdb[%0d]", k), cdb2v(cdb_out), cdb2v(seq_exp[k]));
      chk($sformatf("drain_occ[%0d]", k), 64'(occupancy), 64'((k < 3) ? 2 : 1));
      if (k + 2 < 4) issue_op = seq_op[k+2];
      else           issue_valid = 1'b0;
      @(negedge clk);
    end
    chk("drain_empty_req", 64'(cdb_req), 64'd0);
    chk("drain_empty_occ", 64'(occupancy), 64'd0);

    // Flush with two ops in flight and a same-cycle issue
    cdb_grant   = 1'b0;
    issue_op    = vecs[0].op;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_op    = vecs[1].op;
    @(negedge clk);
    chk("fl_occ_pre", 64'(occupancy), 64'd2);
    flush       = 1'b1;
    cdb_grant   = 1'b1;
    issue_op    = vecs[2].op;
    #1;
    chk("fl_ready", 64'(issue_ready), 64'd0);
    @(negedge clk);
    flush       = 1'b0;
    issue_valid = 1'b0;
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_req", 64'(cdb_req), 64'd0);
    chk("fl_cdb", cdb2v(cdb_out), 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | cdb_req;
    end
    chk("fl_dropped", 64'(seen), 64'd0);

    // Reset while an op is in flight
    cdb_grant   = 1'b0;
    issue_op    = vecs[0].op;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    chk("mr_occ_pre", 64'(occupancy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_occ", 64'(occupancy), 64'd0);
    chk("mr_req", 64'(cdb_req), 64'd0);
    #1;
    rst_n     = 1'b1;
    cdb_grant = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | cdb_req;
    end
    chk("mr_no_emit", 64'(seen), 64'd0);
    chk("mr_ready", 64'(issue_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
